fsm_serial_tx: RTL and testbench



---
 rtl/fsm_pkg.sv | 18 +
 rtl/fsm_serial_tx_if.sv | 9 +
 rtl/ones_mod4_tracker.sv | 34 +++
 rtl/fsm_serial_tx.sv | 118 +++++++++++
 tb/tb_fsm_serial_tx.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/fsm_pkg.sv
// Shared definitions for the serial transmitter and the ones-counting detector models.
package fsm_pkg;
  localparam logic [3:0] TX_IDLE  = 4'b0001;
  localparam logic [3:0] TX_SHIFT = 4'b0010;
  localparam logic [3:0] TX_PAR   = 4'b0100;
  localparam logic [3:0] TX_GAP   = 4'b1000;

  typedef enum logic [3:0] {
    S_IDLE  = TX_IDLE,
    S_SHIFT = TX_SHIFT,
    S_PAR   = TX_PAR,
    S_GAP   = TX_GAP
  } tx_state_e;

  typedef logic [1:0] ones_cnt_t;

  localparam int ONES_PER_FLAG = 4;
endpackage

// File: rtl/fsm_serial_tx_if.sv
// Word handshake into the serial transmitter.
interface fsm_serial_tx_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/ones_mod4_tracker.sv
// Mod-4 ones counter watching the serial line; pulses flag_exp one cycle after every 4th one.
module ones_mod4_tracker
  import fsm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic data,
  output logic flag_exp
);
  ones_cnt_t cnt_q, cnt_d;
  logic      flag_q, flag_d;

  // Wraps 3->0 on the 4th one, same as the detector's s3->s0 step.
  always_comb begin
    cnt_d  = cnt_q;
    flag_d = 1'b0;
    if (data) begin
      cnt_d  = cnt_q + 2'd1;
      flag_d = (cnt_q == ones_cnt_t'(ONES_PER_FLAG - 1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign flag_exp = flag_q;
endmodule

// File: rtl/fsm_serial_tx.sv
// MSB-first serial transmitter with optional even-parity bit (FSM_TX_PARITY_EN) and
// forced idle gap; carries a ones-count model that predicts the detector's flag.
module fsm_serial_tx
  import fsm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic            clk,
  input  logic            rst,
  fsm_serial_tx_if.slave  tx,
  output logic            data,
  output logic            busy,
  output logic            flag_exp
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    bcnt_q, bcnt_d;
  logic [3:0]       gcnt_q, gcnt_d;
  logic             data_q, data_d;
`ifdef FSM_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  // The MSB goes out on the accept edge, so the register holds the remaining bits.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    bcnt_d  = bcnt_q;
    gcnt_d  = gcnt_q;
    data_d  = 1'b0;
`ifdef FSM_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (tx.in_valid) begin
          data_d  = tx.in_data[WIDTH-1];
          sreg_d  = tx.in_data << 1;
          bcnt_d  = CW'(WIDTH - 1);
          state_d = S_SHIFT;
`ifdef FSM_TX_PARITY_EN
          par_d   = ^tx.in_data;
`endif
        end
      end
      S_SHIFT: begin
        if (bcnt_q != '0) begin
          data_d = sreg_q[WIDTH-1];
          sreg_d = sreg_q << 1;
          bcnt_d = bcnt_q - 1'b1;
        end else begin
`ifdef FSM_TX_PARITY_EN
          data_d  = par_q;
          state_d = S_PAR;
`else
          if (GAP > 0) begin
            state_d = S_GAP;
            gcnt_d  = 4'(GAP - 1);
          end else begin
            state_d = S_IDLE;
          end
`endif
        end
      end
`ifdef FSM_TX_PARITY_EN
      S_PAR: begin
        if (GAP > 0) begin
          state_d = S_GAP;
          gcnt_d  = 4'(GAP - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
`endif
      S_GAP: begin
        if (gcnt_q == 4'd0) state_d = S_IDLE;
        else                gcnt_d  = gcnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      bcnt_q  <= '0;
      gcnt_q  <= '0;
      data_q  <= 1'b0;
`ifdef FSM_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      bcnt_q  <= bcnt_d;
      gcnt_q  <= gcnt_d;
      data_q  <= data_d;
`ifdef FSM_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx.in_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign data        = data_q;

  ones_mod4_tracker u_trk (
    .clk      (clk),
    .rst      (rst),
    .data     (data_q),
    .flag_exp (flag_exp)
  );
endmodule

// File: tb/tb_fsm_serial_tx.sv
// Scoreboard bench: two transmitters (GAP=0 and GAP=2), per-cycle expectations queued at accept.
module tb_fsm_serial_tx;
`ifdef FSM_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int PER0 = 9 + P;
  localparam int PER2 = 11 + P;

  typedef struct packed {
    logic d;
    logic f;
    logic b;
    logic r;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic d0, b0, f0, d2, b2, f2;
  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t q0[$];
  exp_t q2[$];

  fsm_serial_tx_if #(.WIDTH(8)) if0 ();
  fsm_serial_tx_if #(.WIDTH(8)) if2 ();

  fsm_serial_tx #(.WIDTH(8), .GAP(0)) u_dut0 (
    .clk(clk), .rst(rst), .tx(if0), .data(d0), .busy(b0), .flag_exp(f0)
  );
  fsm_serial_tx #(.WIDTH(8), .GAP(2)) u_dut2 (
    .clk(clk), .rst(rst), .tx(if2), .data(d2), .busy(b2), .flag_exp(f2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic act, input logic req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%b required=%b at t=%0t", nm, act, req, $time);
    end
  endtask

  // One entry per cycle from T+1 to the following idle cycle; m marks flag cycles.
  task automatic push_word(input int inst, input logic [7:0] w, input logic [15:0] m);
    int per;
    per = (inst == 0) ? PER0 : PER2;
    for (int i = 0; i < per; i++) begin
      exp_t e;
      if (i < 8)                 e.d = w[7-i];
      else if (P == 1 && i == 8) e.d = ^w;
      else                       e.d = 1'b0;
      e.f = m[i];
      e.b = (i < per - 1);
      e.r = ~e.b;
      if (inst == 0) q0.push_back(e);
      else           q2.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in an idle cycle; returns in the word's trailing idle cycle with in_valid still high.
  task automatic send(input int inst, input logic [7:0] w, input logic [15:0] m,
                      input logic chg, input logic [7:0] nw);
    int per;
    per = (inst == 0) ? PER0 : PER2;
    if (inst == 0) begin if0.in_valid = 1'b1; if0.in_data = w; end
    else           begin if2.in_valid = 1'b1; if2.in_data = w; end
    @(posedge clk);
    push_word(inst, w, m);
    #1;
    for (int i = 1; i < per; i++) begin
      if (chg && i == 3) begin
        if (inst == 0) if0.in_data = nw;
        else           if2.in_data = nw;
      end
      tick();
    end
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    e = '{d: 1'b0, f: 1'b0, b: 1'b0, r: 1'b1};
    if (q0.size() > 0) e = q0.pop_front();
    chk("dut0 data",     d0,           e.d);
    chk("dut0 flag_exp", f0,           e.f);
    chk("dut0 busy",     b0,           e.b);
    chk("dut0 in_ready", if0.in_ready, e.r);
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    e = '{d: 1'b0, f: 1'b0, b: 1'b0, r: 1'b1};
    if (q2.size() > 0) e = q2.pop_front();
    chk("dut2 data",     d2,           e.d);
    chk("dut2 flag_exp", f2,           e.f);
    chk("dut2 busy",     b2,           e.b);
    chk("dut2 in_ready", if2.in_ready, e.r);
  end

  initial begin
    if0.in_valid = 1'b0; if0.in_data = '0;
    if2.in_valid = 1'b0; if2.in_data = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) tick();

    // F0: ones in cycles T+1..T+4, flag in T+5, ready again at T+9
    send(0, 8'hF0, 16'h0010, 1'b0, 8'h00);
    if0.in_valid = 1'b0;
    repeat (2) tick();

    // 81 then 81 with in_valid held: count carries, flag right after 2nd LSB
    send(0, 8'h81, 16'h0000, 1'b0, 8'h00);
    send(0, 8'h81, 16'h0100, 1'b0, 8'h00);
    if0.in_valid = 1'b0;
    repeat (2) tick();

    // GAP=2: in_data switches to 3C mid-word and must wait for IDLE
    send(2, 8'hA5, 16'h0100, 1'b1, 8'h3C);
    send(2, 8'h3C, 16'h0040, 1'b0, 8'h00);
    if2.in_valid = 1'b0;
    repeat (2) tick();

    // Reset while bit 3 of FF is on the line: count must restart from 0
    if0.in_valid = 1'b1;
    if0.in_data  = 8'hFF;
    @(posedge clk);
    push_word(0, 8'hFF, 16'h0010);
    #1 if0.in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    q0.delete();
    repeat (2) tick();
    rst = 1'b1;
    tick();
    send(0, 8'h0F, 16'h0100, 1'b0, 8'h00);
    if0.in_valid = 1'b0;
    repeat (2) tick();

`ifdef FSM_TX_PARITY_EN
    // 07 has three ones; the parity bit is the 4th
    send(0, 8'h07, 16'h0200, 1'b0, 8'h00);
    if0.in_valid = 1'b0;
    repeat (2) tick();
`endif

    repeat (3) tick();
    chk("scoreboard drained", (q0.size() == 0 && q2.size() == 0), 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
